// File: rtl/cp0_nest_sched.sv
// Nested interrupt scheduler: edge-latched sources, priority select, held req/ack
// handshake to the pipeline, and an {EPC, previous level} stack for preemption.
module cp0_nest_sched #(
    parameter int          NSRC       = 3,
    parameter int          DEPTH      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    localparam int         LW         = $clog2(NSRC + 1),
    localparam int         DW         = $clog2(DEPTH + 1),
    localparam int         SW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] intsrc,
    input  logic [NSRC-1:0] mask,
    input  logic            ie,
    input  logic [31:0]     ex_pc,
    input  logic            int_ack,
    input  logic            eret,
    output logic            int_req,
    output logic [31:0]     vector,
    output logic [31:0]     epc_out,
    output logic [LW-1:0]   cur_level,
    output logic [DW-1:0]   depth,
    output logic [NSRC-1:0] pending,
    output logic            nest_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] prev_q, pending_q, pending_d, req_bits_s, clr_s;
    logic [SW-1:0]   sel_q, sel_d, cand_idx_s;
    logic            cand_vld_s, eligible_s, entry_s, withdraw_s, push_s, pop_s, int_req_s;
    logic            nest_err_q, nest_err_d;
    logic [31:0]     vector_q, vector_d, epc_top_s;
    logic [LW-1:0]   cur_level_q, cur_level_d, lvl_top_s;
    logic [DW-1:0]   depth_q, depth_d;
    logic [31:0]     epc_stk_q [DEPTH];
    logic [31:0]     epc_stk_d [DEPTH];
    logic [LW-1:0]   lvl_stk_q [DEPTH];
    logic [LW-1:0]   lvl_stk_d [DEPTH];

    // Highest-index enabled pending source and whether it may be requested now
    always_comb begin
        req_bits_s = pending_q & mask;
        cand_vld_s = |req_bits_s;
        cand_idx_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            cand_idx_s = req_bits_s[i] ? SW'(i) : cand_idx_s;
        end
        eligible_s = cand_vld_s && ie
                     && ((LW'(cand_idx_s) + LW'(1)) > cur_level_q)
                     && (depth_q < DW'(DEPTH));
    end

    // Top-of-stack view; an empty stack reads as zero
    always_comb begin
        epc_top_s = 32'h0000_0000;
        lvl_top_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            epc_top_s = (depth_q == DW'(i + 1)) ? epc_stk_q[i] : epc_top_s;
            lvl_top_s = (depth_q == DW'(i + 1)) ? lvl_stk_q[i] : lvl_top_s;
        end
    end

    // FSM outputs and handshake events
    always_comb begin
        int_req_s  = (state_q == REQ);
        entry_s    = int_req_s && int_ack;
        withdraw_s = int_req_s && (!ie || !mask[sel_q] || eret);
        push_s     = entry_s;
        // an eret arriving with the ack is flushed by the pipeline, so it is not a pop
        pop_s      = eret && !entry_s && (depth_q != DW'(0));
    end

    // FSM next state; ack takes priority over withdrawal
    always_comb begin
        case (state_q)
            IDLE:    state_d = (eligible_s && !eret) ? REQ : IDLE;
            REQ:     state_d = (entry_s || withdraw_s) ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: pending, request latch, level and stack
    always_comb begin
        clr_s       = entry_s ? (NSRC'(1) << sel_q) : '0;
        pending_d   = (pending_q & ~clr_s) | (intsrc & ~prev_q);
        sel_d       = sel_q;
        vector_d    = vector_q;
        if ((state_q == IDLE) && (state_d == REQ)) begin
            sel_d    = cand_idx_s;
            vector_d = VEC_BASE + (32'(cand_idx_s) * VEC_STRIDE);
        end else begin
            sel_d    = sel_q;
        end
        nest_err_d  = eret && !entry_s && (depth_q == DW'(0));
        cur_level_d = push_s ? (LW'(sel_q) + LW'(1)) : (pop_s ? lvl_top_s : cur_level_q);
        depth_d     = push_s ? (depth_q + DW'(1)) : (pop_s ? (depth_q - DW'(1)) : depth_q);
        for (int i = 0; i < DEPTH; i++) begin
            epc_stk_d[i] = (push_s && (depth_q == DW'(i))) ? ex_pc :
                           ((pop_s && (depth_q == DW'(i + 1))) ? 32'h0000_0000 : epc_stk_q[i]);
            lvl_stk_d[i] = (push_s && (depth_q == DW'(i))) ? cur_level_q :
                           ((pop_s && (depth_q == DW'(i + 1))) ? '0 : lvl_stk_q[i]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            pending_q   <= '0;
            sel_q       <= '0;
            vector_q    <= 32'h0000_0000;
            cur_level_q <= '0;
            depth_q     <= '0;
            nest_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                epc_stk_q[i] <= 32'h0000_0000;
                lvl_stk_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            prev_q      <= intsrc;
            pending_q   <= pending_d;
            sel_q       <= sel_d;
            vector_q    <= vector_d;
            cur_level_q <= cur_level_d;
            depth_q     <= depth_d;
            nest_err_q  <= nest_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                epc_stk_q[i] <= epc_stk_d[i];
                lvl_stk_q[i] <= lvl_stk_d[i];
            end
        end
    end

    assign int_req   = int_req_s;
    assign vector    = vector_q;
    assign epc_out   = epc_top_s;
    assign cur_level = cur_level_q;
    assign depth     = depth_q;
    assign pending   = pending_q;
    assign nest_err  = nest_err_q;

endmodule

// File: tb/tb_cp0_nest_sched.sv
// Directed bench for cp0_nest_sched: a DEPTH=3 instance for the main flows and a
// DEPTH=1 instance for the full-stack case.
module tb_cp0_nest_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mask;
    logic        ie;
    logic [31:0] ex_pc;

    logic [2:0]  intsrc;
    logic        int_ack, eret;
    logic        int_req, nest_err;
    logic [31:0] vector, epc_out;
    logic [1:0]  cur_level, depth;
    logic [2:0]  pending;

    logic [2:0]  intsrc1;
    logic        int_ack1, eret1;
    logic        int_req1, nest_err1;
    logic [31:0] vector1, epc_out1;
    logic [1:0]  cur_level1;
    logic [0:0]  depth1;
    logic [2:0]  pending1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cp0_nest_sched #(.NSRC(3), .DEPTH(3)) u0 (
        .clk(clk), .rst(rst), .intsrc(intsrc), .mask(mask), .ie(ie), .ex_pc(ex_pc),
        .int_ack(int_ack), .eret(eret), .int_req(int_req), .vector(vector),
        .epc_out(epc_out), .cur_level(cur_level), .depth(depth), .pending(pending),
        .nest_err(nest_err)
    );

    cp0_nest_sched #(.NSRC(3), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .intsrc(intsrc1), .mask(mask), .ie(ie), .ex_pc(ex_pc),
        .int_ack(int_ack1), .eret(eret1), .int_req(int_req1), .vector(vector1),
        .epc_out(epc_out1), .cur_level(cur_level1), .depth(depth1), .pending(pending1),
        .nest_err(nest_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input logic [2:0] s);
        intsrc = s; tick(1); intsrc = 3'b000;
    endtask

    task automatic ack0(input logic [31:0] pc);
        ex_pc = pc; int_ack = 1'b1; tick(1); int_ack = 1'b0;
    endtask

    task automatic eret0();
        eret = 1'b1; tick(1); eret = 1'b0;
    endtask

    initial begin
        rst = 1'b0; mask = 3'b111; ie = 1'b1; ex_pc = 32'h0;
        intsrc = 3'b000; int_ack = 1'b0; eret = 1'b0;
        intsrc1 = 3'b000; int_ack1 = 1'b0; eret1 = 1'b0;
        tick(2);
        check("rst_req", {31'd0, int_req}, 32'd0);
        check("rst_vec", vector, 32'd0);
        check("rst_epc", epc_out, 32'd0);
        check("rst_lvl_dep_pend", {25'd0, cur_level, depth, pending}, 32'd0);
        rst = 1'b1;
        tick(1);

        // Full stack on the DEPTH=1 instance
        intsrc1 = 3'b001; tick(1); intsrc1 = 3'b000; tick(1);
        check("d1_req0", {31'd0, int_req1}, 32'd1);
        int_ack1 = 1'b1; ex_pc = 32'h60; tick(1); int_ack1 = 1'b0;
        check("d1_lvl1", {30'd0, cur_level1}, 32'd1);
        intsrc1 = 3'b100; tick(1); intsrc1 = 3'b000; tick(2);
        check("d1_full_noreq", {31'd0, int_req1}, 32'd0);
        check("d1_full_pend", {29'd0, pending1}, 32'd4);
        eret1 = 1'b1; tick(1); eret1 = 1'b0;
        check("d1_pop_dep", {31'd0, depth1}, 32'd0);
        tick(1);
        check("d1_rereq", {31'd0, int_req1}, 32'd1);
        check("d1_vec", vector1, 32'h820);
        int_ack1 = 1'b1; tick(1); int_ack1 = 1'b0;
        eret1 = 1'b1; tick(1); eret1 = 1'b0;

        // Single source
        intsrc = 3'b010; tick(1); intsrc = 3'b000;
        check("s_pend", {29'd0, pending}, 32'd2);
        check("s_lat1", {31'd0, int_req}, 32'd0);
        tick(1);
        check("s_req", {31'd0, int_req}, 32'd1);
        check("s_vec", vector, 32'h810);
        ack0(32'h100);
        check("s_ack_req", {31'd0, int_req}, 32'd0);
        check("s_lvl", {30'd0, cur_level}, 32'd2);
        check("s_dep", {30'd0, depth}, 32'd1);
        check("s_epc", epc_out, 32'h100);
        check("s_pend_clr", {29'd0, pending}, 32'd0);
        eret0();
        check("s_eret_lvl", {30'd0, cur_level}, 32'd0);
        check("s_eret_dep", {30'd0, depth}, 32'd0);
        check("s_eret_epc", epc_out, 32'd0);

        // Preemption
        pulse0(3'b001); tick(1);
        check("p_vec0", vector, 32'h800);
        ack0(32'h200);
        pulse0(3'b100); tick(1);
        check("p_req2", {31'd0, int_req}, 32'd1);
        check("p_vec2", vector, 32'h820);
        ack0(32'h840);
        check("p_dep2", {30'd0, depth}, 32'd2);
        check("p_epc2", epc_out, 32'h840);
        check("p_lvl3", {30'd0, cur_level}, 32'd3);
        eret0();
        check("p_pop_epc", epc_out, 32'h200);
        check("p_pop_lvl", {30'd0, cur_level}, 32'd1);
        eret0();
        check("p_pop_dep", {30'd0, depth}, 32'd0);

        // Blocking by running level
        pulse0(3'b100); tick(1); ack0(32'h280);
        pulse0(3'b010); tick(2);
        check("b_noreq", {31'd0, int_req}, 32'd0);
        check("b_pend", {29'd0, pending}, 32'd2);
        eret0();
        check("b_eret_lvl", {30'd0, cur_level}, 32'd0);
        check("b_eret_noreq", {31'd0, int_req}, 32'd0);
        tick(1);
        check("b_req", {31'd0, int_req}, 32'd1);
        check("b_vec", vector, 32'h810);

        // Withdrawal on ie drop
        ie = 1'b0; tick(1);
        check("w_req", {31'd0, int_req}, 32'd0);
        check("w_dep", {30'd0, depth}, 32'd0);
        check("w_pend", {29'd0, pending}, 32'd2);
        ie = 1'b1; tick(1);
        check("w_rereq", {31'd0, int_req}, 32'd1);

        // Ack together with eret: push, no pop
        ex_pc = 32'h300; int_ack = 1'b1; eret = 1'b1; tick(1); int_ack = 1'b0; eret = 1'b0;
        check("ae_dep", {30'd0, depth}, 32'd1);
        check("ae_lvl", {30'd0, cur_level}, 32'd2);
        check("ae_epc", epc_out, 32'h300);
        check("ae_nerr", {31'd0, nest_err}, 32'd0);
        eret0();

        // Eret on empty stack
        eret0();
        check("ne_pulse", {31'd0, nest_err}, 32'd1);
        check("ne_state", {25'd0, cur_level, depth, pending}, 32'd0);
        tick(1);
        check("ne_end", {31'd0, nest_err}, 32'd0);

        // Pending set and clear on the same ack edge
        pulse0(3'b010); tick(1);
        ex_pc = 32'h380; intsrc = 3'b010; int_ack = 1'b1; tick(1);
        intsrc = 3'b000; int_ack = 1'b0;
        check("sc_pend", {29'd0, pending}, 32'd2);
        check("sc_dep", {30'd0, depth}, 32'd1);
        tick(1);
        check("sc_block", {31'd0, int_req}, 32'd0);
        eret0(); tick(1);
        check("sc_rereq", {31'd0, int_req}, 32'd1);
        check("sc_vec", vector, 32'h810);
        ack0(32'h400);
        check("sc_pend_clr", {29'd0, pending}, 32'd0);
        eret0();

        // Asynchronous reset mid-request at depth 2
        pulse0(3'b001); tick(1); ack0(32'h10);
        pulse0(3'b010); tick(1); ack0(32'h20);
        pulse0(3'b100); tick(1);
        check("r_pre_req", {31'd0, int_req}, 32'd1);
        check("r_pre_dep", {30'd0, depth}, 32'd2);
        #2 rst = 1'b0;
        #1;
        check("r_req", {31'd0, int_req}, 32'd0);
        check("r_vec", vector, 32'd0);
        check("r_epc", epc_out, 32'd0);
        check("r_lvl_dep_pend", {25'd0, cur_level, depth, pending}, 32'd0);
        tick(1);
        rst = 1'b1;
        tick(3);
        check("r_post_noreq", {31'd0, int_req}, 32'd0);
        check("r_post_pend", {29'd0, pending}, 32'd0);
        pulse0(3'b100); tick(1);
        check("r_new_req", {31'd0, int_req}, 32'd1);
        check("r_new_vec", vector, 32'h820);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
